// File: rtl/regfile_wr_arb.sv
// rtl/regfile_wr_arb.sv - write-port controller for the 2R/1W regfile: clear sweep plus round-robin arbitration
//
// Purpose:
//   Owns the single write port of `regfile`. After reset, and on i_clr, it
//   sweeps zeros into every entry (INIT). Otherwise (RUN) it grants the port
//   to one of two valid/ready requesters with round-robin priority.
//
// Ports:
//   i_clk, i_rstn                 clock (rising edge), async active-low reset
//   i_clr                         request a full clear sweep (ignored in INIT)
//   i_reqN_valid/addr/data        requester N write request and payload
//   o_reqN_ready                  requester N accepted when valid & ready
//   o_rf_wr_en/addr/data          registered write port to `regfile`
//   o_init_done                   registered, high while in RUN

module regfile_wr_arb #(
    parameter int BW_DATA = 16,
    parameter int BW_ADDR = 4
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_clr,
    input  logic               i_req0_valid,
    input  logic [BW_ADDR-1:0] i_req0_addr,
    input  logic [BW_DATA-1:0] i_req0_data,
    output logic               o_req0_ready,
    input  logic               i_req1_valid,
    input  logic [BW_ADDR-1:0] i_req1_addr,
    input  logic [BW_DATA-1:0] i_req1_data,
    output logic               o_req1_ready,
    output logic               o_rf_wr_en,
    output logic [BW_ADDR-1:0] o_rf_wr_addr,
    output logic [BW_DATA-1:0] o_rf_wr_data,
    output logic               o_init_done
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // One extra counter bit so the "sweep finished" value never aliases entry 0.
    localparam logic [BW_ADDR:0] CNT_END = (BW_ADDR+1)'(2**BW_ADDR);
    localparam logic [BW_ADDR:0] CNT_ONE = (BW_ADDR+1)'(1);

    state_t             state_q, state_d;
    logic [BW_ADDR:0]   cnt_q, cnt_d;
    logic               ptr_q, ptr_d;
    logic               wr_en_q, wr_en_d;
    logic [BW_ADDR-1:0] wr_addr_q, wr_addr_d;
    logic [BW_DATA-1:0] wr_data_q, wr_data_d;
    logic               init_done_q, init_done_d;

    logic ready0, ready1;

    // Grant: a lone valid wins; on contention the pointer decides. A pending
    // clear blocks both so no write is accepted in the cycle that leaves RUN.
    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (state_q == S_RUN && !i_clr) begin
            ready0 = i_req0_valid && (!i_req1_valid || (ptr_q == 1'b0));
            ready1 = i_req1_valid && (!i_req0_valid || (ptr_q == 1'b1));
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        init_done_d = init_done_q;

        case (state_q)
            S_INIT: begin
                if (cnt_q == CNT_END) begin
                    state_d     = S_RUN;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[BW_ADDR-1:0];
                    wr_data_d = '0;
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end
            S_RUN: begin
                if (i_clr) begin
                    state_d     = S_INIT;
                    cnt_d       = '0;
                    init_done_d = 1'b0;
                end else if (ready0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = i_req0_addr;
                    wr_data_d = i_req0_data;
                    ptr_d     = 1'b1;
                end else if (ready1) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = i_req1_addr;
                    wr_data_d = i_req1_data;
                    ptr_d     = 1'b0;
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            ptr_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            init_done_q <= init_done_d;
        end
    end

    assign o_req0_ready = ready0;
    assign o_req1_ready = ready1;
    assign o_rf_wr_en   = wr_en_q;
    assign o_rf_wr_addr = wr_addr_q;
    assign o_rf_wr_data = wr_data_q;
    assign o_init_done  = init_done_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb/tb_regfile_wr_arb.sv - self-checking bench for regfile_wr_arb

module tb_regfile_wr_arb;

    logic        i_clk;
    logic        i_rstn;
    logic        i_clr;
    logic        i_req0_valid;
    logic [3:0]  i_req0_addr;
    logic [15:0] i_req0_data;
    logic        o_req0_ready;
    logic        i_req1_valid;
    logic [3:0]  i_req1_addr;
    logic [15:0] i_req1_data;
    logic        o_req1_ready;
    logic        o_rf_wr_en;
    logic [3:0]  o_rf_wr_addr;
    logic [15:0] o_rf_wr_data;
    logic        o_init_done;

    int total = 0;
    int bad   = 0;

    logic [15:0] rf [16];
    logic [15:0] sb [16];

    regfile_wr_arb #(.BW_DATA(16), .BW_ADDR(4)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_clr        (i_clr),
        .i_req0_valid (i_req0_valid),
        .i_req0_addr  (i_req0_addr),
        .i_req0_data  (i_req0_data),
        .o_req0_ready (o_req0_ready),
        .i_req1_valid (i_req1_valid),
        .i_req1_addr  (i_req1_addr),
        .i_req1_data  (i_req1_data),
        .o_req1_ready (o_req1_ready),
        .o_rf_wr_en   (o_rf_wr_en),
        .o_rf_wr_addr (o_rf_wr_addr),
        .o_rf_wr_data (o_rf_wr_data),
        .o_init_done  (o_init_done)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Behavioural stand-in for the downstream regfile storage.
    always @(posedge i_clk) begin
        if (o_rf_wr_en) rf[o_rf_wr_addr] <= o_rf_wr_data;
    end

    typedef struct {
        logic        v0;
        logic [3:0]  a0;
        logic [15:0] d0;
        logic        v1;
        logic [3:0]  a1;
        logic [15:0] d1;
        logic        er0;
        logic        er1;
        logic        een;
        logic [3:0]  eaddr;
        logic [15:0] edata;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drv(input logic v0, input logic [3:0] a0, input logic [15:0] d0,
                       input logic v1, input logic [3:0] a1, input logic [15:0] d1,
                       input logic clr);
        i_req0_valid = v0; i_req0_addr = a0; i_req0_data = d0;
        i_req1_valid = v1; i_req1_addr = a1; i_req1_data = d1;
        i_clr = clr;
    endtask

    // Checks a full 16-entry zero sweep starting with the next edge, then entry to RUN.
    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk({tag, "_en"}, o_rf_wr_en, 1);
            chk({tag, "_addr"}, o_rf_wr_addr, i);
            chk({tag, "_data"}, o_rf_wr_data, 0);
            chk({tag, "_done"}, o_init_done, 0);
            chk({tag, "_rdy"}, {o_req0_ready, o_req1_ready}, 0);
        end
        tick();
        chk({tag, "_end_en"}, o_rf_wr_en, 0);
        chk({tag, "_end_done"}, o_init_done, 1);
    endtask

    initial begin
        logic [15:0] rd;

        vt[0] = '{1'b1, 4'h1, 16'h1111, 1'b1, 4'h2, 16'h2222, 1'b1, 1'b0, 1'b1, 4'h1, 16'h1111};
        vt[1] = '{1'b1, 4'h1, 16'h1111, 1'b1, 4'h2, 16'h2222, 1'b0, 1'b1, 1'b1, 4'h2, 16'h2222};
        vt[2] = '{1'b1, 4'h1, 16'h1111, 1'b1, 4'h2, 16'h2222, 1'b1, 1'b0, 1'b1, 4'h1, 16'h1111};
        vt[3] = '{1'b1, 4'h1, 16'h1111, 1'b1, 4'h2, 16'h2222, 1'b0, 1'b1, 1'b1, 4'h2, 16'h2222};
        vt[4] = '{1'b1, 4'h3, 16'hBEEF, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h3, 16'hBEEF};
        vt[5] = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h3, 16'hBEEF};
        vt[6] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h5, 16'h5555, 1'b0, 1'b1, 1'b1, 4'h5, 16'h5555};
        vt[7] = '{1'b1, 4'h7, 16'h7777, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h7, 16'h7777};
        vt[8] = '{1'b1, 4'h8, 16'h8888, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h8, 16'h8888};
        vt[9] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'hC, 16'hC0DE, 1'b0, 1'b1, 1'b1, 4'hC, 16'hC0DE};

        i_rstn = 1'b0;
        drv(1'b1, 4'h3, 16'hAAAA, 1'b1, 4'h4, 16'hBBBB, 1'b0);
        repeat (2) tick();

        chk("rst_en", o_rf_wr_en, 0);
        chk("rst_addr", o_rf_wr_addr, 0);
        chk("rst_data", o_rf_wr_data, 0);
        chk("rst_done", o_init_done, 0);
        chk("rst_rdy", {o_req0_ready, o_req1_ready}, 0);

        i_rstn = 1'b1;
        sweep("init");
        drv(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0);
        tick();
        for (int i = 0; i < 16; i++) chk("init_rf_zero", rf[i], 0);

        for (int k = 0; k < 10; k++) begin
            drv(vt[k].v0, vt[k].a0, vt[k].d0, vt[k].v1, vt[k].a1, vt[k].d1, 1'b0);
            #1;
            chk($sformatf("vec%0d_r0", k), o_req0_ready, vt[k].er0);
            chk($sformatf("vec%0d_r1", k), o_req1_ready, vt[k].er1);
            tick();
            chk($sformatf("vec%0d_en", k), o_rf_wr_en, vt[k].een);
            chk($sformatf("vec%0d_addr", k), o_rf_wr_addr, vt[k].eaddr);
            chk($sformatf("vec%0d_data", k), o_rf_wr_data, vt[k].edata);
        end
        drv(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0);
        tick();
        rd = rf[3];
        chk("rd_addr3", rd, 16'hBEEF);

        // Clear while req1 waits; the write registered just before must still show.
        drv(1'b1, 4'h4, 16'h4444, 1'b0, 4'h0, 16'h0, 1'b0);
        #1;
        chk("pre_clr_r0", o_req0_ready, 1);
        tick();
        drv(1'b0, 4'h0, 16'h0, 1'b1, 4'h9, 16'h9999, 1'b1);
        #1;
        chk("clr_r1", o_req1_ready, 0);
        chk("clr_cycle_en", o_rf_wr_en, 1);
        chk("clr_cycle_addr", o_rf_wr_addr, 4'h4);
        tick();
        i_clr = 1'b0;
        chk("clr_next_en", o_rf_wr_en, 0);
        chk("clr_next_done", o_init_done, 0);
        sweep("clr");
        #1;
        chk("post_clr_r1", o_req1_ready, 1);
        tick();
        chk("post_clr_en", o_rf_wr_en, 1);
        chk("post_clr_addr", o_rf_wr_addr, 4'h9);
        chk("post_clr_data", o_rf_wr_data, 16'h9999);
        drv(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0);

        // Reset mid-sweep once addresses 0..6 have been issued (cnt=7).
        i_rstn = 1'b0;
        tick();
        i_rstn = 1'b1;
        repeat (7) tick();
        chk("mid_addr6", o_rf_wr_addr, 4'h6);
        #2;
        i_rstn = 1'b0;
        #1;
        chk("mid_rst_en", o_rf_wr_en, 0);
        chk("mid_rst_addr", o_rf_wr_addr, 0);
        chk("mid_rst_done", o_init_done, 0);
        tick();
        i_rstn = 1'b1;
        sweep("resweep");

        // Random single-requester writes to every address.
        for (int i = 0; i < 16; i++) begin
            sb[i] = 16'($urandom);
            if (i % 2 == 0) drv(1'b1, 4'(i), sb[i], 1'b0, 4'h0, 16'h0, 1'b0);
            else            drv(1'b0, 4'h0, 16'h0, 1'b1, 4'(i), sb[i], 1'b0);
            #1;
            chk("rnd_ready", {o_req0_ready, o_req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            chk("rnd_en", o_rf_wr_en, 1);
            chk("rnd_addr", o_rf_wr_addr, i);
            chk("rnd_data", o_rf_wr_data, sb[i]);
        end
        drv(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 16; i++) chk($sformatf("rnd_rd%0d", i), rf[i], sb[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
